// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch/data requester ports and shared memory port of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  i_fetch_req;
  logic [ADDR_WIDTH-1:0] i_fetch_addr;
  logic [DATA_WIDTH-1:0] o_fetch_rdata;
  logic                  o_fetch_done;
  logic                  o_fetch_stall;

  logic                  i_data_req;
  logic                  i_data_we;
  logic [ADDR_WIDTH-1:0] i_data_addr;
  logic [DATA_WIDTH-1:0] i_data_wdata;
  logic [DATA_WIDTH-1:0] o_data_rdata;
  logic                  o_data_done;
  logic                  o_data_stall;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_wdata;
  logic                  i_mem_ack;
  logic [DATA_WIDTH-1:0] i_mem_rdata;

  // Arbiter side: it masters the shared memory and serves both requesters.
  modport master (
    input  i_fetch_req, i_fetch_addr,
    output o_fetch_rdata, o_fetch_done, o_fetch_stall,
    input  i_data_req, i_data_we, i_data_addr, i_data_wdata,
    output o_data_rdata, o_data_done, o_data_stall,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    output i_fetch_req, i_fetch_addr,
    input  o_fetch_rdata, o_fetch_done, o_fetch_stall,
    output i_data_req, i_data_we, i_data_addr, i_data_wdata,
    input  o_data_rdata, o_data_done, o_data_stall,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between fetch and data requesters,
//            data-priority with a bounded starvation limit for fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 2
) (
  input wire logic            i_clk,
  input wire logic            i_reset,
  mem_port_arbiter_if.master  bus
);

  localparam logic [2:0] C_STARVE_LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY_FETCH = 2'd1,
    BUSY_DATA  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_starve_cnt;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_fetch_rdata;
  logic [DATA_WIDTH-1:0] r_data_rdata;
  logic                  r_fetch_done;
  logic                  r_data_done;

  logic                  w_fetch_wins;
  logic                  w_grant_fetch;
  logic                  w_grant_data;
  logic                  w_ack;

  // Fetch only overrides data once it has lost STARVE_LIMIT times in a row.
  assign w_fetch_wins = bus.i_fetch_req &&
                        (!bus.i_data_req || (r_starve_cnt == C_STARVE_LIMIT));

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_fetch = 1'b0;
    w_grant_data  = 1'b0;
    w_ack         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fetch_wins) begin
          w_grant_fetch = 1'b1;
          w_state_nxt   = BUSY_FETCH;
        end else if (bus.i_data_req) begin
          w_grant_data  = 1'b1;
          w_state_nxt   = BUSY_DATA;
        end
      end
      BUSY_FETCH, BUSY_DATA: begin
        if (bus.i_mem_ack && r_mem_req) begin
          w_ack       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_starve_cnt  <= 3'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_fetch_rdata <= '0;
      r_data_rdata  <= '0;
      r_fetch_done  <= 1'b0;
      r_data_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_done <= 1'b0;
      r_data_done  <= 1'b0;

      if (w_grant_fetch) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_addr   <= bus.i_fetch_addr;
        r_mem_wdata  <= '0;
        r_starve_cnt <= 3'd0;
      end else if (w_grant_data) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= bus.i_data_we;
        r_mem_addr   <= bus.i_data_addr;
        r_mem_wdata  <= bus.i_data_wdata;
        if (!bus.i_fetch_req) begin
          r_starve_cnt <= 3'd0;
        end else if (r_starve_cnt != C_STARVE_LIMIT) begin
          r_starve_cnt <= r_starve_cnt + 3'd1;
        end
      end else if ((r_state == IDLE) && !bus.i_fetch_req) begin
        r_starve_cnt <= 3'd0;
      end

      if (w_ack) begin
        r_mem_req <= 1'b0;
        if (r_state == BUSY_FETCH) begin
          r_fetch_rdata <= bus.i_mem_rdata;
          r_fetch_done  <= 1'b1;
        end else begin
          r_data_done <= 1'b1;
          // Stores complete without disturbing the last load value.
          if (!r_mem_we) begin
            r_data_rdata <= bus.i_mem_rdata;
          end
        end
      end
    end
  end

  assign bus.o_mem_req     = r_mem_req;
  assign bus.o_mem_we      = r_mem_we;
  assign bus.o_mem_addr    = r_mem_addr;
  assign bus.o_mem_wdata   = r_mem_wdata;
  assign bus.o_fetch_rdata = r_fetch_rdata;
  assign bus.o_fetch_done  = r_fetch_done;
  assign bus.o_data_rdata  = r_data_rdata;
  assign bus.o_data_done   = r_data_done;
  assign bus.o_fetch_stall = bus.i_fetch_req && !r_fetch_done;
  assign bus.o_data_stall  = bus.i_data_req && !r_data_done;

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 32, memory data width.
- STARVE_LIMIT, 2, consecutive data-port wins allowed while fetch waits; range 1..7.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, single clock; all state updates on the rising edge.
- i_reset, in, 1, asynchronous, active-high reset.
- i_fetch_req, in, 1, fetch-stage read request.
- i_fetch_addr, in, ADDR_WIDTH, fetch address.
- o_fetch_rdata, out, DATA_WIDTH, fetch read data, registered.
- o_fetch_done, out, 1, one-cycle fetch completion pulse.
- o_fetch_stall, out, 1, fetch stage must hold.
- i_data_req, in, 1, memory-stage request (LW/SW).
- i_data_we, in, 1, 1 = write (SW), 0 = read (LW).
- i_data_addr, in, ADDR_WIDTH, data address.
- i_data_wdata, in, DATA_WIDTH, store data.
- o_data_rdata, out, DATA_WIDTH, load data, registered.
- o_data_done, out, 1, one-cycle data completion pulse.
- o_data_stall, out, 1, memory stage must hold.
- o_mem_req, out, 1, request to the shared single-port memory.
- o_mem_we, out, 1, memory write enable.
- o_mem_addr, out, ADDR_WIDTH, memory address.
- o_mem_wdata, out, DATA_WIDTH, memory write data.
- i_mem_ack, in, 1, memory completion; read data valid in the same cycle.
- i_mem_rdata, in, DATA_WIDTH, memory read data.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY_FETCH, BUSY_DATA.
REQ-004 In IDLE with no request pending, the FSM SHALL stay in IDLE with o_mem_req=0.
REQ-005 In IDLE with exactly one request, the FSM SHALL grant that requester at the next edge.
REQ-006 In IDLE with both requests, data SHALL win unless starve_cnt == STARVE_LIMIT, in which case fetch SHALL win.
REQ-007 On a grant, the arbiter SHALL register addr/we/wdata (fetch: we=0, wdata=0) and assert o_mem_req from the next cycle.
REQ-008 o_mem_req and the registered command SHALL be held constant until the cycle in which i_mem_ack=1.
REQ-009 On the ack edge, the arbiter SHALL:
- capture i_mem_rdata into the owner's rdata register (data-port writes leave o_data_rdata unchanged);
- pulse the owner's done for exactly one cycle;
- drop o_mem_req;
- return to IDLE.
REQ-010 After every transaction the FSM SHALL spend at least one cycle in IDLE; no back-to-back grants.
REQ-011 Latency SHALL be as follows: request sampled at edge N gives o_mem_req high in cycle N+1; ack in cycle M gives done high in cycle M+1. Minimum request-to-done time is 2 cycles.
REQ-012 Stall outputs SHALL be combinational: o_x_stall = i_x_req AND NOT o_x_done.
REQ-013 starve_cnt is a 3-bit counter that SHALL:
- increment on each data grant made while i_fetch_req=1;
- clear on any fetch grant;
- clear in any IDLE cycle with i_fetch_req=0;
- saturate at STARVE_LIMIT.
REQ-014 A requester SHALL hold its req and command until its done pulse. If req drops mid-transaction, the arbiter SHALL still complete the transaction and pulse done.
REQ-015 i_mem_ack SHALL be ignored in IDLE.
REQ-016 i_mem_ack SHALL be acted on only while o_mem_req=1.
REQ-017 Requests arriving in BUSY states SHALL wait and be arbitrated in the next IDLE cycle.
REQ-018 rdata registers SHALL hold their value until overwritten by a later read to the same port.

Reset
REQ-019 On i_reset=1, the arbiter SHALL immediately (asynchronously) force state=IDLE, starve_cnt=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_fetch_done=0, o_data_done=0, o_fetch_rdata=0 and o_data_rdata=0.
REQ-020 Reset asserted mid-transaction SHALL abandon that transaction without a done pulse. An i_mem_ack arriving after reset SHALL be ignored.
REQ-021 After reset deassertion, the first arbitration SHALL occur at the first rising edge with i_reset=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Lone fetch: addr=0x10, ack 3 cycles after o_mem_req, rdata=0xDEADBEEF -> o_fetch_done pulses once; o_fetch_rdata=0xDEADBEEF; o_fetch_stall=1 until the done cycle.
- Simultaneous requests: fetch 0x20 and data read 0x80 in the same cycle -> data served first, then 1 IDLE cycle, then fetch served.
- Starvation: fetch held high; data issues 3 back-to-back requests; STARVE_LIMIT=2 -> grant order data, data, fetch, data.
- Store: i_data_we=1, addr=0x44, wdata=0x12345678 -> o_mem_we=1, o_mem_addr=0x44, o_mem_wdata=0x12345678 held until ack; o_data_rdata unchanged.
- Reset mid-transaction: reset during BUSY_DATA before ack -> o_mem_req=0 immediately; no o_data_done; a late ack is ignored.
- Stray ack: i_mem_ack=1 in IDLE -> no done pulse; no state change.
